// File: rtl/sync_fifo_ctrl.sv
// First-word-fall-through FIFO controller around an external 1-cycle SDP RAM.
// Optional SYNC_FIFO_CTRL_WATERMARK_EN adds AFULL_THRESH and almost_full.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
    ,
    parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 4
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
    output logic                  almost_full,
`endif
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_P = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    logic [ADDR_WIDTH:0] ram_cnt;
    logic                wr_fire;
    logic                rd_issue;

    // Extra pointer MSB separates a full RAM from an empty one
    assign ram_cnt  = wr_ptr - rd_ptr;
    assign full     = (ram_cnt == DEPTH_P);
    assign s_ready  = !full && !rst;
    assign wr_fire  = s_valid && s_ready;
    assign rd_issue = (ram_cnt != '0) && (!m_valid || m_ready) && !rst;

    assign ram_ena   = wr_fire;
    assign ram_wea   = wr_fire;
    assign ram_addra = wr_ptr[ADDR_WIDTH-1:0];
    assign ram_dina  = s_data;
    assign ram_enb   = rd_issue;
    assign ram_addrb = rd_ptr[ADDR_WIDTH-1:0];

    // RAM output register doubles as the FIFO output stage
    assign m_data = ram_doutb;
    assign count  = ram_cnt + {{ADDR_WIDTH{1'b0}}, m_valid};
    assign empty  = (count == '0);

`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
    assign almost_full = !rst && (int'(count) >= AFULL_THRESH);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            m_valid <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_issue) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                m_valid <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences an external simple dual-port RAM instance (one write port, one read port, 1-cycle registered read) as a first-word-fall-through FIFO. Provides valid/ready stream interfaces on both sides and drives the RAM enables and addresses. The RAM's registered read output serves directly as the FIFO output stage. Used wherever the team needs stream buffering deeper than flops allow.

Parameters:
DATA_WIDTH, 32, word width; must match the attached RAM.
ADDR_WIDTH, 10, RAM address width; RAM capacity DEPTH = 2^ADDR_WIDTH words.

Ports:
clk  input  1  single clock; drives both RAM clocks.
rst  input  1  synchronous, active-high reset.
s_valid  input  1  write-side word valid.
s_ready  output  1  write-side ready.
s_data  input  DATA_WIDTH  write-side data.
m_valid  output  1  read-side word valid.
m_ready  input  1  read-side ready.
m_data  output  DATA_WIDTH  read-side data (= ram_doutb).
count  output  ADDR_WIDTH+1  words held (RAM + output stage), 0..DEPTH+1.
full  output  1  RAM full (s_ready low).
empty  output  1  no word anywhere (count == 0).
ram_ena, ram_wea  output  1 each  RAM write port enable / write enable.
ram_addra  output  ADDR_WIDTH  RAM write address.
ram_dina  output  DATA_WIDTH  RAM write data.
ram_enb  output  1  RAM read port enable.
ram_addrb  output  ADDR_WIDTH  RAM read address.
ram_doutb  input  DATA_WIDTH  RAM registered read data.

Behaviour:
- One clock (clk); synchronous active-high reset (rst).
- State: wr_ptr, rd_ptr (ADDR_WIDTH+1 bits each, extra wrap bit), m_valid flag. ram_cnt = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- Reset: wr_ptr = rd_ptr = 0, m_valid = 0; so count = 0, empty = 1, full = 0. While rst is high: s_ready = 0, ram_ena = ram_enb = 0. s_ready = 1 the first cycle after rst deasserts. RAM contents are not cleared.
- full = (ram_cnt == DEPTH). s_ready = !full && !rst. No write pass-through when full, even if a read occurs in the same cycle.
- Write: wr_fire = s_valid && s_ready. Drives ram_ena = ram_wea = wr_fire, ram_addra = wr_ptr[ADDR_WIDTH-1:0], ram_dina = s_data. wr_ptr increments on wr_fire.
- Prefetch read: rd_issue = (ram_cnt != 0) && (!m_valid || m_ready) && !rst. Drives ram_enb = rd_issue, ram_addrb = rd_ptr[ADDR_WIDTH-1:0]. rd_ptr increments on rd_issue.
- Output stage update at the next edge:
  - rd_issue: m_valid <= 1.
  - else if m_valid && m_ready: m_valid <= 0.
  - else: hold.
- m_data = ram_doutb. The RAM holds its output while ram_enb = 0, so m_data stays stable under backpressure.
- ram_cnt uses registered pointers only, so a word written in cycle t is readable no earlier than t+1. Latency from s_valid&&s_ready in an empty FIFO to m_valid is 2 cycles. Sustained throughput is 1 word/cycle both sides.
- Simultaneous write and read: both pointers advance; ram_cnt unchanged. Read and write addresses are never equal with ram_cnt != 0 at full, so no read-during-write hazard.
- count = ram_cnt + m_valid. Both count and full are combinational from registered state.
- Pointer wrap: indices wrap at DEPTH. The extra MSB distinguishes full from empty.
- Reset mid-operation: all in-flight words are discarded. m_valid drops the cycle after rst is sampled.

Optional Feature:
Macro SYNC_FIFO_CTRL_WATERMARK_EN.
- Defined: adds parameter AFULL_THRESH (default DEPTH-4) and output port almost_full (1 bit). almost_full = (count >= AFULL_THRESH); it is 0 during and after reset until the threshold is reached.
- Undefined: no parameter, no port, no logic.

Test Plan:
1. ADDR_WIDTH=2. Write 0xA5 into the empty FIFO at cycle 0, m_ready=1 -> m_valid=1, m_data=0xA5 at cycle 2; empty=1 at cycle 3.
2. ADDR_WIDTH=2, m_ready=0. Write 6 words 1..6 back-to-back -> 5 accepted (4 in RAM + 1 in the output stage), count=5, full=1, s_ready=0. Drain with m_ready=1 -> outputs 1..5 in order with no bubbles.
3. Continuous s_valid and m_ready for 20 cycles with incrementing data -> 1 word/cycle, in order, count steady at 1–2, pointers wrap with no loss.
4. Random m_ready toggling while m_valid=1 -> m_data holds unchanged whenever m_ready=0; no duplicates, no drops over 100 words.
5. rst pulsed for 1 cycle with count=3 -> next cycle count=0, m_valid=0, empty=1, s_ready=1. A new word 0x3C then appears as the first output.
6. With SYNC_FIFO_CTRL_WATERMARK_EN, ADDR_WIDTH=3, AFULL_THRESH=6 -> almost_full rises on the cycle count reaches 6 and falls when count drops to 5.
